// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - EX-stage handshake bundle between the pipeline and the HI/LO multiply/divide unit
interface muldiv_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start;
    logic [2:0]            Op;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  Flush;
    logic                  Busy;
    logic                  Done;
    logic                  Stall;
    logic                  DivByZero;
    logic [DATA_WIDTH-1:0] HI;
    logic [DATA_WIDTH-1:0] LO;

    modport master (
        output Start, Op, A, B, Flush,
        input  Busy, Done, Stall, DivByZero, HI, LO
    );

    modport slave (
        input  Start, Op, A, B, Flush,
        output Busy, Done, Stall, DivByZero, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes
module muldiv_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [W-1:0]   opd_q, opd_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           neg_rem_q, neg_rem_d;
    logic           div0_q, div0_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    logic           a_neg, b_neg;
    logic [W-1:0]   a_mag, b_mag;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;
    logic [W:0]     div_shift, div_diff;
    logic [2*W-1:0] div_next;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quo_s, rem_s;

    // Op[0]=0 selects the signed flavour of MULT/DIV.
    assign a_neg = ~bus.Op[0] & bus.A[W-1];
    assign b_neg = ~bus.Op[0] & bus.B[W-1];
    assign a_mag = a_neg ? -bus.A : bus.A;
    assign b_mag = b_neg ? -bus.B : bus.B;

    // Multiply: multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opd_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: remainder in the high half, dividend bits shift into it, quotient bits fill the low half.
    assign div_shift = acc_q[2*W-1:W-1];
    assign div_diff  = div_shift - {1'b0, opd_q};
    assign div_next  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};

    assign prod_s = neg_q     ? -acc_q           : acc_q;
    assign quo_s  = neg_q     ? -acc_q[W-1:0]    : acc_q[W-1:0];
    assign rem_s  = neg_rem_q ? -acc_q[2*W-1:W]  : acc_q[2*W-1:W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
        if (bus.Flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.Start && !bus.Op[2]) begin
                        state_d   = S_RUN;
                        cnt_d     = '0;
                        is_div_d  = bus.Op[1];
                        acc_d     = {{W{1'b0}}, (bus.Op[1] ? a_mag : b_mag)};
                        opd_d     = bus.Op[1] ? b_mag : a_mag;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        div0_d    = (bus.B == '0);
                    end else if (bus.Start && bus.Op[1:0] == 2'b00) begin
                        hi_d = bus.A;
                    end else if (bus.Start && bus.Op[1:0] == 2'b01) begin
                        lo_d = bus.A;
                    end
                end
                S_RUN: begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_d = S_SIGN;
                    end
                end
                S_SIGN: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    dbz_d   = is_div_q & div0_q;
                    // With a zero divisor the remainder path already reproduces A; only LO is forced.
                    if (is_div_q) begin
                        hi_d = rem_s;
                        lo_d = div0_q ? {W{1'b1}} : quo_s;
                    end else begin
                        {hi_d, lo_d} = prod_s;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opd_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.Busy      = (state_q != S_IDLE);
    assign bus.Done      = done_q;
    assign bus.Stall     = bus.Start & bus.Busy & ~bus.Flush;
    assign bus.DivByZero = dbz_q;
    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide execution unit with architectural HI/LO registers. It sits beside the ALU in the EX stage of the pipelined MIPS core and adds MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multi-cycle operations run under a start/busy/done handshake, and the unit raises a stall request to the hazard logic. A flush input lets branch or jump redirection cancel an in-flight operation.

## Interface
- DATA_WIDTH, 32, operand, HI and LO width; must be even and ≥ 4.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- Start  input  1  operation request, sampled each rising edge.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved (no effect).
- A  input  DATA_WIDTH  rs operand (multiplicand, dividend, or MTHI/MTLO source).
- B  input  DATA_WIDTH  rt operand (multiplier or divisor).
- Flush  input  1  abort the in-flight operation and drop any Start in the same cycle.
- Busy  output  1  multi-cycle operation in progress.
- Done  output  1  one-cycle pulse; HI and LO have just been updated by MULT/DIV.
- Stall  output  1  combinational: Start & Busy & ~Flush.
- DivByZero  output  1  registered; valid while Done=1, held until the next Done.
- HI  output  DATA_WIDTH  high product word or remainder.
- LO  output  DATA_WIDTH  low product word or quotient.

## Operation
- State machine IDLE → RUN → SIGN → IDLE.
- IDLE, Start=1, Flush=0, Op=MULT/MULTU/DIV/DIVU:
  - Latch magnitudes of A and B. Signed ops take two's-complement absolute values; unsigned ops take A and B as given.
  - Latch the result-sign flags and clear the iteration counter. Next state RUN.
- IDLE, Start=1, Flush=0, Op=MTHI/MTLO:
  - HI (or LO) ← A at that edge.
  - Stay in IDLE, no Busy, no Done.
- RUN executes one iteration per cycle for exactly DATA_WIDTH cycles:
  - Multiply: shift-add into a 2×DATA_WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - After the last iteration, next state SIGN.
- SIGN applies sign correction, then writes HI/LO at the edge leaving SIGN. Next state IDLE.
  - MULT: 2W-bit product is negated if the operand signs differ.
  - DIV: quotient is negated if the signs differ; remainder takes the dividend's sign.
- Divisor 0: LO ← all ones, HI ← A (raw, unsigned or signed), DivByZero ← 1. Otherwise DivByZero ← 0 on each Done.
- DIV of most-negative by −1: LO ← 0x80..0, HI ← 0. No trap.
- Start while Busy: ignored, Stall=1. The pipeline holds the instruction and re-presents it.
- Flush=1 in any state: next state IDLE, counter cleared, HI/LO/DivByZero unchanged, no Done. This includes Flush during the SIGN cycle. Flush has priority over Start.
- reset=1, including mid-operation: state IDLE, HI=0, LO=0, Busy=0, Done=0, DivByZero=0. reset has priority over everything.
- Reserved Op values: accepted as no-ops (stay IDLE).

## Timing
- Start accepted at edge 0:
  - Busy=1 for cycles 1..DATA_WIDTH+1 (DATA_WIDTH RUN cycles plus 1 SIGN cycle).
  - At edge DATA_WIDTH+2: HI/LO valid, Busy=0, Done=1 for one cycle.
  - Latency for DATA_WIDTH=32 is 34 edges.
- In the Done cycle the state is IDLE: a new Start is accepted at that edge (back-to-back issue with no bubble). Done deasserts at the next edge.
- MTHI/MTLO: HI/LO visible in the cycle after the accepting edge.
- HI/LO are stable outside update edges. Readers (MFHI/MFLO) must stall while Busy=1.

## Test plan
- Sign handling, MULT: reset, MULT A=0xFFFFFFFD (−3), B=7 → Done at edge 34; HI=0xFFFFFFFF, LO=0xFFFFFFEB, Busy high for cycles 1..33.
- Unsigned multiply: MULTU A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then a back-to-back MULT 2×3 issued in the Done cycle → HI=0, LO=6 at 34 edges later.
- Signed divide and overflow case:
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, DivByZero=0.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: DIVU 7/0 → LO=0xFFFFFFFF, HI=7, DivByZero=1. Follow with DIVU 9/4 → LO=2, HI=1, DivByZero=0.
- Handshake and flush: MULT 5×5 with HI/LO preloaded via MTHI 0xAA / MTLO 0xBB.
  - Start again at cycle 5 → Stall=1, no effect.
  - Flush at cycle 10 → Busy=0 at cycle 11, no Done, HI=0xAA, LO=0xBB.
  - Repeat with Flush in the SIGN cycle (cycle 33) → same retained values.
- Reset during RUN: reset=1 at cycle 12 of DIVU → next cycle Busy=0, Done=0, HI=LO=0, DivByZero=0. A fresh MULTU 3×4 then completes in 34 edges → LO=12.
